// File: rtl/ex_wb_flags_stage_pkg.sv
// Shared constants for the EX->WB flags stage: flag vector indices, EFLAGS bit
// positions, operand size codes and the EFLAGS packing helper.
package ex_wb_flags_stage_pkg;

    localparam int FLAG_W = 6;

    // Index into the 6-bit {OF,SF,ZF,AF,PF,CF} flag vector
    localparam int CF = 0;
    localparam int PF = 1;
    localparam int AF = 2;
    localparam int ZF = 3;
    localparam int SF = 4;
    localparam int OF = 5;

    localparam int EF_CF = 0;
    localparam int EF_PF = 2;
    localparam int EF_AF = 4;
    localparam int EF_ZF = 6;
    localparam int EF_SF = 7;
    localparam int EF_DF = 10;
    localparam int EF_OF = 11;

    typedef enum logic [1:0] {
        SIZE_8  = 2'd0,
        SIZE_16 = 2'd1,
        SIZE_32 = 2'd2
    } size_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_e;

    // Bit 1 of EFLAGS is architecturally reserved as 1
    function automatic logic [31:0] pack_eflags(input logic [FLAG_W-1:0] f, input logic df);
        logic [31:0] e;
        e        = 32'h0000_0002;
        e[EF_CF] = f[CF];
        e[EF_PF] = f[PF];
        e[EF_AF] = f[AF];
        e[EF_ZF] = f[ZF];
        e[EF_SF] = f[SF];
        e[EF_DF] = df;
        e[EF_OF] = f[OF];
        return e;
    endfunction

endpackage

// File: rtl/ex_wb_flags_stage_flag_merge.sv
// Per-bit select between a held (younger) flag value and the architectural
// value, taken only where the load enable is set and the entry is live.
module flag_merge #(
    parameter int W = 7
) (
    input  logic         en,
    input  logic [W-1:0] held,
    input  logic [W-1:0] ld,
    input  logic [W-1:0] arch,
    output logic [W-1:0] merged
);

    logic [W-1:0] take;

    assign take   = ld & {W{en}};
    assign merged = (held & take) | (arch & ~take);

endmodule

// File: rtl/ex_wb_flags_stage.sv
// EX->WB pipeline register holding the ALU result and pending flag update,
// plus the architectural EFLAGS state and CF/AF/DF forwarding back to EX.
module ex_wb_flags_stage
    import ex_wb_flags_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DST_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              flush,
    input  logic              wb_stall,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [5:0]        ex_flags,
    input  logic [5:0]        ex_cmps_flags,
    input  logic              ex_sel_cmps,
    input  logic [5:0]        ex_ld_flags,
    input  logic              ex_df_val,
    input  logic              ex_ld_df,
    input  logic              ex_ld_reg,
    input  logic [DST_W-1:0]  ex_dst_id,
    input  logic [1:0]        ex_dst_size,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_res,
    output logic              wb_ld_reg,
    output logic [DST_W-1:0]  wb_dst_id,
    output logic [1:0]        wb_dst_size,
    output logic [5:0]        flags_q,
    output logic              df_q,
    output logic [31:0]       eflags32,
    output logic              fwd_CF,
    output logic              fwd_AF,
    output logic              fwd_DF
);

    wb_state_e         state_q, state_d;
    logic              capture, retire;
    logic [DATA_W-1:0] res_p1;
    logic [5:0]        flags_p1, ld_flags_p1;
    logic              df_p1, ld_df_p1, ld_reg_p1;
    logic [DST_W-1:0]  dst_id_p1;
    size_e             dst_size_p1;
    logic [6:0]        commit_vec;
    logic [2:0]        fwd_vec;

    assign wb_valid = (state_q == FULL);
    assign ex_ready = !wb_valid || !wb_stall;
    assign capture  = ex_valid && ex_ready && !flush;
    // A retiring entry commits even when flush empties the stage on the same edge
    assign retire   = wb_valid && !wb_stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (capture) state_d = FULL;
            FULL:    if (!capture && (retire || flush)) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // ---- EX -> WB register (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1      <= '0;
            flags_p1    <= '0;
            ld_flags_p1 <= '0;
            df_p1       <= 1'b0;
            ld_df_p1    <= 1'b0;
            ld_reg_p1   <= 1'b0;
            dst_id_p1   <= '0;
            dst_size_p1 <= SIZE_8;
        end else if (capture) begin
            res_p1      <= ex_res;
            flags_p1    <= ex_sel_cmps ? ex_cmps_flags : ex_flags;
            ld_flags_p1 <= ex_ld_flags;
            df_p1       <= ex_df_val;
            ld_df_p1    <= ex_ld_df;
            ld_reg_p1   <= ex_ld_reg;
            dst_id_p1   <= ex_dst_id;
            dst_size_p1 <= size_e'(ex_dst_size);
        end
    end

    assign wb_res      = res_p1;
    assign wb_ld_reg   = ld_reg_p1 && wb_valid;
    assign wb_dst_id   = dst_id_p1;
    assign wb_dst_size = dst_size_p1;

    // ---- WB commit into architectural EFLAGS ----
    flag_merge #(.W(7)) u_commit (
        .en     (retire),
        .held   ({df_p1, flags_p1}),
        .ld     ({ld_df_p1, ld_flags_p1}),
        .arch   ({df_q, flags_q}),
        .merged (commit_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            df_q    <= 1'b0;
        end else begin
            flags_q <= commit_vec[5:0];
            df_q    <= commit_vec[6];
        end
    end

    assign eflags32 = pack_eflags(flags_q, df_q);

    flag_merge #(.W(3)) u_fwd (
        .en     (wb_valid),
        .held   ({df_p1, flags_p1[AF], flags_p1[CF]}),
        .ld     ({ld_df_p1, ld_flags_p1[AF], ld_flags_p1[CF]}),
        .arch   ({df_q, flags_q[AF], flags_q[CF]}),
        .merged (fwd_vec)
    );

    assign fwd_CF = fwd_vec[0];
    assign fwd_AF = fwd_vec[1];
    assign fwd_DF = fwd_vec[2];

endmodule

// File: tb/tb_ex_wb_flags_stage.sv
// Bench for ex_wb_flags_stage: vector table through a result scoreboard, plus
// hand-built stall, flush, forwarding and asynchronous reset sequences.
module tb_ex_wb_flags_stage;

    localparam int DATA_W = 32;
    localparam int DST_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid, ex_ready, flush, wb_stall;
    logic [DATA_W-1:0] ex_res, wb_res;
    logic [5:0]        ex_flags, ex_cmps_flags, ex_ld_flags, flags_q;
    logic              ex_sel_cmps, ex_df_val, ex_ld_df, ex_ld_reg;
    logic [DST_W-1:0]  ex_dst_id, wb_dst_id;
    logic [1:0]        ex_dst_size, wb_dst_size;
    logic              wb_valid, wb_ld_reg, df_q, fwd_CF, fwd_AF, fwd_DF;
    logic [31:0]       eflags32;

    always #5 clk = ~clk;

    ex_wb_flags_stage #(.DATA_W(DATA_W), .DST_W(DST_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .flush(flush), .wb_stall(wb_stall), .ex_res(ex_res), .ex_flags(ex_flags),
        .ex_cmps_flags(ex_cmps_flags), .ex_sel_cmps(ex_sel_cmps),
        .ex_ld_flags(ex_ld_flags), .ex_df_val(ex_df_val), .ex_ld_df(ex_ld_df),
        .ex_ld_reg(ex_ld_reg), .ex_dst_id(ex_dst_id), .ex_dst_size(ex_dst_size),
        .wb_valid(wb_valid), .wb_res(wb_res), .wb_ld_reg(wb_ld_reg),
        .wb_dst_id(wb_dst_id), .wb_dst_size(wb_dst_size), .flags_q(flags_q),
        .df_q(df_q), .eflags32(eflags32), .fwd_CF(fwd_CF), .fwd_AF(fwd_AF),
        .fwd_DF(fwd_DF)
    );

    typedef struct {
        logic [31:0] res;
        logic [5:0]  flags;
        logic [5:0]  cmps;
        logic        sel;
        logic [5:0]  ld;
        logic        df;
        logic        ld_df;
        logic [5:0]  exp_flags;
        logic        exp_df;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ld_reg;
        logic [2:0]  dst;
        logic [1:0]  size;
        logic [5:0]  exp_flags;
        logic        exp_df;
    } sb_t;

    sb_t        sb[$];
    sb_t        mon_e;
    vec_t       tbl[9];
    vec_t       v;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         pend = 1'b0;
    logic [5:0] pend_flags;
    logic       pend_df;

    function automatic logic [31:0] ef_model(input logic [5:0] f, input logic df);
        return 32'h2 | (32'(f[0]) << 0) | (32'(f[1]) << 2) | (32'(f[2]) << 4)
             | (32'(f[3]) << 6) | (32'(f[4]) << 7) | (32'(df) << 10) | (32'(f[5]) << 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t d, input logic [2:0] dst, input logic ld_reg,
                         input logic [1:0] size, input bit push);
        sb_t s;
        ex_valid      = 1'b1;
        ex_res        = d.res;
        ex_flags      = d.flags;
        ex_cmps_flags = d.cmps;
        ex_sel_cmps   = d.sel;
        ex_ld_flags   = d.ld;
        ex_df_val     = d.df;
        ex_ld_df      = d.ld_df;
        ex_ld_reg     = ld_reg;
        ex_dst_id     = dst;
        ex_dst_size   = size;
        if (push) begin
            s.res = d.res; s.ld_reg = ld_reg; s.dst = dst; s.size = size;
            s.exp_flags = d.exp_flags; s.exp_df = d.exp_df;
            sb.push_back(s);
        end
    endtask

    // Retire happens at the next rising edge whenever WB is valid and not stalled here
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                chk("commit flags_q", 32'(flags_q), 32'(pend_flags));
                chk("commit df_q", 32'(df_q), 32'(pend_df));
                chk("commit eflags32", eflags32, ef_model(pend_flags, pend_df));
                pend = 1'b0;
            end
            if (wb_valid && !wb_stall) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected retire: wb_res %h with empty scoreboard", wb_res);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wb_res", wb_res, mon_e.res);
                    chk("wb_ld_reg", 32'(wb_ld_reg), 32'(mon_e.ld_reg));
                    chk("wb_dst_id", 32'(wb_dst_id), 32'(mon_e.dst));
                    chk("wb_dst_size", 32'(wb_dst_size), 32'(mon_e.size));
                    pend_flags = mon_e.exp_flags;
                    pend_df    = mon_e.exp_df;
                    pend       = 1'b1;
                end
            end
        end
    end

    initial begin
        ex_valid = 0; flush = 0; wb_stall = 0; ex_res = '0; ex_flags = '0;
        ex_cmps_flags = '0; ex_sel_cmps = 0; ex_ld_flags = '0; ex_df_val = 0;
        ex_ld_df = 0; ex_ld_reg = 0; ex_dst_id = '0; ex_dst_size = '0;

        step(); step();
        chk("reset wb_valid", 32'(wb_valid), 32'h0);
        chk("reset flags_q", 32'(flags_q), 32'h0);
        chk("reset eflags32", eflags32, 32'h2);
        chk("reset wb_res", wb_res, 32'h0);
        chk("reset ex_ready", 32'(ex_ready), 32'h1);
        rst_n = 1'b1;
        step();

        //         res    flags  cmps   sel ld     df ldf  exp   edf
        tbl[0] = '{32'h11, 6'h09, 6'h00, 0, 6'h3F, 0, 0, 6'h09, 0};
        tbl[1] = '{32'h22, 6'h3F, 6'h00, 0, 6'h3F, 0, 0, 6'h3F, 0};
        tbl[2] = '{32'h33, 6'h00, 6'h3F, 0, 6'h01, 0, 0, 6'h3E, 0};
        tbl[3] = '{32'h44, 6'h15, 6'h2A, 0, 6'h00, 0, 0, 6'h3E, 0};
        tbl[4] = '{32'h55, 6'h3F, 6'h10, 1, 6'h3F, 0, 0, 6'h10, 0};
        tbl[5] = '{32'h66, 6'h00, 6'h00, 0, 6'h00, 1, 1, 6'h10, 1};
        tbl[6] = '{32'h77, 6'h2A, 6'h00, 0, 6'h0F, 0, 0, 6'h1A, 1};
        tbl[7] = '{32'h88, 6'h25, 6'h00, 0, 6'h20, 0, 0, 6'h3A, 1};
        tbl[8] = '{32'h99, 6'h00, 6'h03, 1, 6'h03, 0, 1, 6'h3B, 0};

        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i], 3'(i), i[0], 2'(i % 3), 1'b1);
            step();
            if (i == 0) begin
                chk("latency wb_valid", 32'(wb_valid), 32'h1);
                chk("latency wb_res", wb_res, 32'h11);
            end
            if (i == 1) begin
                chk("ADD flags_q", 32'(flags_q), 32'h09);
                chk("ADD eflags32", eflags32, 32'h43);
            end
        end
        ex_valid = 1'b0;
        step(); step();

        // Forwarding: clear CF, then hold a CF/AF/DF producer under stall
        v = '{32'hF0, 6'h00, 6'h00, 0, 6'h01, 0, 0, 6'h3A, 0};
        drive(v, 3'd1, 1'b1, 2'd2, 1'b1);
        step();
        v = '{32'hF1, 6'h05, 6'h00, 0, 6'h05, 1, 1, 6'h3F, 1};
        drive(v, 3'd2, 1'b1, 2'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        wb_stall = 1'b1;
        #1;
        chk("fwd arch CF is 0", 32'(flags_q[0]), 32'h0);
        chk("fwd_CF from WB", 32'(fwd_CF), 32'h1);
        chk("fwd_AF from WB", 32'(fwd_AF), 32'h1);
        chk("fwd_DF from WB", 32'(fwd_DF), 32'h1);
        chk("fwd arch DF is 0", 32'(df_q), 32'h0);
        step();
        wb_stall = 1'b0;
        step();
        chk("fwd after retire valid", 32'(wb_valid), 32'h0);
        chk("fwd_CF from arch", 32'(fwd_CF), 32'h1);
        chk("fwd_DF from arch", 32'(fwd_DF), 32'h1);
        step();

        // Stall A for two cycles while B waits, then B and C back-to-back
        v = '{32'hA0, 6'h00, 6'h00, 0, 6'h3F, 1, 0, 6'h00, 1};
        drive(v, 3'd3, 1'b1, 2'd0, 1'b1);
        step();
        wb_stall = 1'b1;
        v = '{32'hB0, 6'h06, 6'h00, 0, 6'h02, 0, 0, 6'h02, 1};
        drive(v, 3'd4, 1'b0, 2'd1, 1'b1);
        #1;
        chk("stall ex_ready", 32'(ex_ready), 32'h0);
        step();
        chk("stall hold A 1", wb_res, 32'hA0);
        chk("stall ex_ready 2", 32'(ex_ready), 32'h0);
        step();
        chk("stall hold A 2", wb_res, 32'hA0);
        chk("stall wb_valid", 32'(wb_valid), 32'h1);
        wb_stall = 1'b0;
        step();
        chk("B after stall", wb_res, 32'hB0);
        v = '{32'hC0, 6'h20, 6'h00, 0, 6'h21, 0, 0, 6'h22, 1};
        drive(v, 3'd5, 1'b1, 2'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        step(); step();

        // Flush of a stalled entry discards it without commit
        v = '{32'hE0, 6'h15, 6'h00, 0, 6'h3F, 0, 1, 6'h15, 0};
        drive(v, 3'd6, 1'b1, 2'd2, 1'b0);
        step();
        ex_valid = 1'b0;
        wb_stall = 1'b1;
        flush    = 1'b1;
        step();
        chk("flush stalled wb_valid", 32'(wb_valid), 32'h0);
        chk("flush stalled flags_q", 32'(flags_q), 32'h22);
        chk("flush stalled df_q", 32'(df_q), 32'h1);
        flush    = 1'b0;
        wb_stall = 1'b0;

        // Flush of a retiring entry still commits, and blocks the new capture
        v = '{32'hF5, 6'h15, 6'h00, 0, 6'h3F, 0, 1, 6'h15, 0};
        drive(v, 3'd7, 1'b1, 2'd2, 1'b1);
        step();
        flush = 1'b1;
        v = '{32'hDEAD, 6'h00, 6'h00, 0, 6'h3F, 1, 1, 6'h00, 1};
        drive(v, 3'd0, 1'b1, 2'd2, 1'b0);
        step();
        chk("flush retire wb_valid", 32'(wb_valid), 32'h0);
        chk("flush retire flags_q", 32'(flags_q), 32'h15);
        chk("flush retire df_q", 32'(df_q), 32'h0);
        flush    = 1'b0;
        ex_valid = 1'b0;
        step(); step();

        // Asynchronous reset mid-cycle with an entry held
        mon_en = 1'b0;
        v = '{32'h77, 6'h3F, 6'h00, 0, 6'h3F, 1, 1, 6'h3F, 1};
        drive(v, 3'd1, 1'b1, 2'd1, 1'b0);
        step();
        ex_valid = 1'b0;
        wb_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset wb_valid", 32'(wb_valid), 32'h0);
        chk("async reset flags_q", 32'(flags_q), 32'h0);
        chk("async reset df_q", 32'(df_q), 32'h0);
        chk("async reset eflags32", eflags32, 32'h2);
        chk("async reset wb_res", wb_res, 32'h0);
        chk("async reset fwd_CF", 32'(fwd_CF), 32'h0);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
